// File: rtl/cache_refill_ctl.sv
// Data-cache miss handler: writes back a dirty victim, refills the missing line beat by beat, pulses the response.
// Optional macro CACHE_REFILL_CTL_PERF_EN adds miss/evict/stall performance counters.
module cache_refill_ctl #(
  parameter int LINE_BITS  = 512,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cache_miss,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                  i_evict,
  input  logic [ADDR_WIDTH-1:0] i_evict_addr,
  input  logic [LINE_BITS-1:0]  i_evict_data,
  output logic                  o_stall,
  output logic [LINE_BITS-1:0]  o_memory_line,
  output logic                  o_memory_response,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [BUS_WIDTH-1:0]  o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [BUS_WIDTH-1:0]  i_mem_rdata,
  output logic [1:0]            o_dbg_state
`ifdef CACHE_REFILL_CTL_PERF_EN
  ,
  output logic [31:0]           o_miss_count,
  output logic [31:0]           o_evict_count,
  output logic [31:0]           o_stall_cycles
`endif
);

  localparam int BEATS = LINE_BITS / BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((LINE_BITS / 8) - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BUS_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST      = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WRBACK, REFILL, RESP} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat;
  logic [ADDR_WIDTH-1:0]   miss_base;
  logic [LINE_BITS-1:0]    evict_line;
  logic [ADDR_WIDTH-1:0]   miss_line_addr;
  logic [ADDR_WIDTH-1:0]   evict_line_addr;
  logic                    beat_ack;
  logic                    last_beat;

  assign miss_line_addr  = i_miss_addr & ~OFF_MASK;
  assign evict_line_addr = i_evict_addr & ~OFF_MASK;
  // Handshake: a beat (req/we/addr/wdata) is held unchanged while o_mem_req is high and
  // completes in the cycle i_mem_ack is high; ack with req low carries no meaning.
  assign beat_ack    = o_mem_req & i_mem_ack;
  assign last_beat   = (beat == LAST);
  assign o_stall     = (state != IDLE) | ((state == IDLE) & i_cache_miss);
  assign o_dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      beat              <= '0;
      o_mem_req         <= 1'b0;
      o_mem_we          <= 1'b0;
      o_memory_response <= 1'b0;
      o_mem_addr        <= '0;
      o_mem_wdata       <= '0;
      o_memory_line     <= '0;
      miss_base         <= '0;
      evict_line        <= '0;
    end else begin
      o_memory_response <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cache_miss) begin
            miss_base   <= miss_line_addr;
            // Victim lanes go out lowest first; the remainder shifts down each accepted beat.
            o_mem_wdata <= i_evict_data[BUS_WIDTH-1:0];
            evict_line  <= i_evict_data >> BUS_WIDTH;
            beat        <= '0;
            o_mem_req   <= 1'b1;
            if (i_evict) begin
              state      <= WRBACK;
              o_mem_we   <= 1'b1;
              o_mem_addr <= evict_line_addr;
            end else begin
              state      <= REFILL;
              o_mem_we   <= 1'b0;
              o_mem_addr <= miss_line_addr;
            end
          end
        end
        WRBACK: begin
          if (beat_ack) begin
            if (last_beat) begin
              state      <= REFILL;
              beat       <= '0;
              o_mem_we   <= 1'b0;
              o_mem_addr <= miss_base;
            end else begin
              beat        <= beat + CNT_W'(1);
              o_mem_addr  <= o_mem_addr + ADDR_STEP;
              o_mem_wdata <= evict_line[BUS_WIDTH-1:0];
              evict_line  <= evict_line >> BUS_WIDTH;
            end
          end
        end
        REFILL: begin
          if (beat_ack) begin
            o_memory_line[int'(beat)*BUS_WIDTH +: BUS_WIDTH] <= i_mem_rdata;
            if (last_beat) begin
              state             <= RESP;
              beat              <= '0;
              o_mem_req         <= 1'b0;
              o_memory_response <= 1'b1;
            end else begin
              beat       <= beat + CNT_W'(1);
              o_mem_addr <= o_mem_addr + ADDR_STEP;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_REFILL_CTL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_miss_count   <= '0;
      o_evict_count  <= '0;
      o_stall_cycles <= '0;
    end else begin
      if (state == IDLE && i_cache_miss) begin
        o_miss_count <= o_miss_count + 32'd1;
        if (i_evict) o_evict_count <= o_evict_count + 32'd1;
      end
      if (o_stall) o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_ctl.sv
// Directed bench for cache_refill_ctl: clean, dirty, wait-state, mid-reset and back-to-back misses.
// Performance counters are checked when CACHE_REFILL_CTL_PERF_EN is defined.
module tb_cache_refill_ctl;
  localparam int LB = 512;
  localparam int BW = 32;
  localparam int AW = 32;
  localparam int N  = LB / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cache_miss, i_evict, i_mem_ack;
  logic [AW-1:0] i_miss_addr, i_evict_addr;
  logic [LB-1:0] i_evict_data;
  logic [BW-1:0] i_mem_rdata;
  logic          o_stall, o_memory_response, o_mem_req, o_mem_we;
  logic [LB-1:0] o_memory_line;
  logic [AW-1:0] o_mem_addr;
  logic [BW-1:0] o_mem_wdata;
  logic [1:0]    o_dbg_state;
`ifdef CACHE_REFILL_CTL_PERF_EN
  logic [31:0]   o_miss_count, o_evict_count, o_stall_cycles;
`endif

  cache_refill_ctl #(.LINE_BITS(LB), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_cache_miss(i_cache_miss), .i_miss_addr(i_miss_addr), .i_evict(i_evict),
    .i_evict_addr(i_evict_addr), .i_evict_data(i_evict_data),
    .o_stall(o_stall), .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_dbg_state(o_dbg_state)
`ifdef CACHE_REFILL_CTL_PERF_EN
    , .o_miss_count(o_miss_count), .o_evict_count(o_evict_count), .o_stall_cycles(o_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  logic [31:0] salt;

  // Observations from the most recent run_miss call.
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic        obs_we[$];
  int          obs_cyc[$];
  int          rsp_cycle, stall_cnt, unstable;
  logic        stall_after;
  logic [LB-1:0] rsp_line, line_after;

  // Scoreboard expected queues.
  logic [31:0] exp_q[$];
  logic [31:0] exp_d_q[$];
  logic        exp_we_q[$];
  int          exp_c_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {salt[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int k = 0; k < N; k++) l[k*BW +: BW] = $urandom;
    return l;
  endfunction

  task automatic apply_reset();
    rst = 1'b0; i_cache_miss = 1'b0; i_evict = 1'b0; i_mem_ack = 1'b0;
    i_miss_addr = '0; i_evict_addr = '0; i_evict_data = '0; i_mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Memory-side driver: raises a miss, acks every beat after wait_cyc idle cycles,
  // records beats, drops the miss one cycle after the response.
  task automatic run_miss(input logic [31:0] maddr, input logic ev, input logic [31:0] eaddr,
                          input logic [LB-1:0] edata, input int wait_cyc);
    int wcnt;
    bit done;
    logic prev_req, prev_ack, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    obs_addr.delete(); obs_data.delete(); obs_we.delete(); obs_cyc.delete();
    rsp_cycle = -1; stall_cnt = 0; unstable = 0; stall_after = 1'b1; line_after = '0; rsp_line = '0;
    wcnt = 0; done = 0; prev_req = 0; prev_ack = 0; prev_we = 0; prev_addr = '0; prev_wdata = '0;
    @(negedge clk);
    i_cache_miss = 1'b1; i_miss_addr = maddr; i_evict = ev; i_evict_addr = eaddr; i_evict_data = edata;
    for (int c = 0; c < 600 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        i_miss_addr = $urandom; i_evict_addr = $urandom; i_evict_data = rand_line();
        i_evict = 1'($urandom_range(0, 1));
      end
      if (rsp_cycle >= 0) i_cache_miss = 1'b0;
      #1;
      if (rsp_cycle >= 0) begin
        stall_after = o_stall; line_after = o_memory_line; done = 1;
      end else begin
        if (o_stall) stall_cnt++;
        if (prev_req && !prev_ack && (!o_mem_req || o_mem_addr !== prev_addr ||
            o_mem_we !== prev_we || o_mem_wdata !== prev_wdata)) unstable++;
        if (o_memory_response) begin rsp_cycle = c; rsp_line = o_memory_line; end
        if (o_mem_req) begin
          if (wcnt == wait_cyc) begin i_mem_ack = 1'b1; wcnt = 0; end
          else begin i_mem_ack = 1'b0; wcnt++; end
          i_mem_rdata = mem_word(o_mem_addr);
        end else begin
          i_mem_ack = 1'($urandom_range(0, 1));
          i_mem_rdata = $urandom;
        end
        if (o_mem_req && i_mem_ack) begin
          obs_addr.push_back(o_mem_addr); obs_we.push_back(o_mem_we); obs_cyc.push_back(c);
          obs_data.push_back(o_mem_we ? o_mem_wdata : i_mem_rdata);
        end
        prev_req = o_mem_req; prev_ack = i_mem_ack; prev_we = o_mem_we;
        prev_addr = o_mem_addr; prev_wdata = o_mem_wdata;
      end
    end
    i_mem_ack = 1'b0;
    tests++;
    if (!done) begin
      failed++;
      $display("FAIL run_miss_timeout: no response within 600 cycles (miss addr %h)", maddr);
      apply_reset();
    end
  endtask

  // Compares recorded beats against the expected queues and the refill line against the model.
  task automatic check_seq(input string name, input int exp_rsp, input int exp_stall,
                           input logic [31:0] line_base);
    tests++;
    if (obs_addr.size() !== exp_q.size()) begin
      failed++;
      $display("FAIL %s_beat_count: got %0d beats, want %0d", name, obs_addr.size(), exp_q.size());
    end
    for (int k = 0; k < obs_addr.size() && exp_q.size() > 0; k++) begin
      logic [31:0] ea, ed; logic ew; int ec;
      ea = exp_q.pop_front(); ed = exp_d_q.pop_front(); ew = exp_we_q.pop_front(); ec = exp_c_q.pop_front();
      tests++;
      if (obs_addr[k] !== ea || obs_we[k] !== ew || obs_data[k] !== ed || obs_cyc[k] !== ec) begin
        failed++;
        $display("FAIL %s_beat%0d: got addr=%h we=%b data=%h cyc=%0d, want addr=%h we=%b data=%h cyc=%0d",
                 name, k, obs_addr[k], obs_we[k], obs_data[k], obs_cyc[k], ea, ew, ed, ec);
      end
    end
    exp_q.delete(); exp_d_q.delete(); exp_we_q.delete(); exp_c_q.delete();
    tests++;
    if (rsp_cycle !== exp_rsp) begin
      failed++; $display("FAIL %s_rsp_cycle: got %0d, want %0d", name, rsp_cycle, exp_rsp);
    end
    tests++;
    if (stall_cnt !== exp_stall) begin
      failed++; $display("FAIL %s_stall_cycles: got %0d, want %0d", name, stall_cnt, exp_stall);
    end
    tests++;
    if (unstable !== 0) begin
      failed++; $display("FAIL %s_req_stable: got %0d changes while waiting, want 0", name, unstable);
    end
    tests++;
    if (stall_after !== 1'b0) begin
      failed++; $display("FAIL %s_stall_after: got %b, want 0", name, stall_after);
    end
    for (int k = 0; k < N; k++) begin
      tests++;
      if (rsp_line[k*BW +: BW] !== mem_word(line_base + 32'(4*k)) ||
          line_after[k*BW +: BW] !== mem_word(line_base + 32'(4*k))) begin
        failed++;
        $display("FAIL %s_line_lane%0d: got %h (held %h), want %h", name, k,
                 rsp_line[k*BW +: BW], line_after[k*BW +: BW], mem_word(line_base + 32'(4*k)));
      end
    end
  endtask

  // Queues N read beats of line `base`, the first acked at first_cyc, spaced by step.
  task automatic expect_reads(input logic [31:0] base, input int first_cyc, input int step);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(base + 32'(4*k)); exp_we_q.push_back(1'b0);
      exp_d_q.push_back(mem_word(base + 32'(4*k))); exp_c_q.push_back(first_cyc + k*step);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_memory_response !== 1'b0) begin
      failed++; $display("FAIL reset_ctrl: got req=%b we=%b rsp=%b, want 0 0 0", o_mem_req, o_mem_we, o_memory_response);
    end
    tests++;
    if (o_mem_addr !== '0 || o_mem_wdata !== '0 || o_memory_line !== '0) begin
      failed++; $display("FAIL reset_data: got addr=%h wdata=%h line nonzero=%b, want 0", o_mem_addr, o_mem_wdata, |o_memory_line);
    end
    tests++;
    if (o_stall !== 1'b0 || o_dbg_state !== 2'd0) begin
      failed++; $display("FAIL reset_state: got stall=%b state=%0d, want 0 0", o_stall, o_dbg_state);
    end
  endtask

  task automatic test_clean_miss();
    salt = $urandom;
    run_miss(32'h0000_1234, 1'b0, 32'h0, '0, 0);
    expect_reads(32'h0000_1200, 1, 1);
    // Response visible in cycle N+1 after the miss cycle, captured by the cache on edge N+2.
    check_seq("clean", N + 1, N + 2, 32'h0000_1200);
  endtask

  task automatic test_dirty_miss();
    logic [LB-1:0] ev;
    salt = $urandom;
    for (int k = 0; k < N; k++) ev[k*BW +: BW] = 32'hA0 + 32'(k);
    run_miss(32'h0000_0040, 1'b1, 32'h0000_8040, ev, 0);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(32'h0000_8040 + 32'(4*k)); exp_we_q.push_back(1'b1);
      exp_d_q.push_back(32'hA0 + 32'(k)); exp_c_q.push_back(1 + k);
    end
    expect_reads(32'h0000_0040, N + 1, 1);
    check_seq("dirty", 2*N + 1, 2*N + 2, 32'h0000_0040);
  endtask

  task automatic test_wait_states();
    salt = $urandom;
    run_miss(32'h0000_3FC8, 1'b0, 32'h0, '0, 3);
    expect_reads(32'h0000_3FC0, 4, 4);
    check_seq("wait3", 4*N + 1, 4*N + 2, 32'h0000_3FC0);
  endtask

  task automatic test_reset_mid();
    int reads;
    bit hit;
    salt = $urandom; reads = 0; hit = 0;
    @(negedge clk);
    i_cache_miss = 1'b1; i_miss_addr = 32'h0000_4000; i_evict = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (o_mem_req && !o_mem_we && reads == 7) begin
        rst = 1'b0;
        #1;
        hit = 1;
        tests++;
        if (o_mem_req !== 1'b0 || o_memory_response !== 1'b0 || o_dbg_state !== 2'd0) begin
          failed++; $display("FAIL midreset_async: got req=%b rsp=%b state=%0d, want 0 0 0", o_mem_req, o_memory_response, o_dbg_state);
        end
        tests++;
        if (o_memory_line !== '0 || o_mem_addr !== '0) begin
          failed++; $display("FAIL midreset_clear: got addr=%h line nonzero=%b, want 0", o_mem_addr, |o_memory_line);
        end
      end else begin
        i_mem_ack = o_mem_req;
        i_mem_rdata = mem_word(o_mem_addr);
        if (o_mem_req) reads++;
      end
    end
    tests++;
    if (!hit) begin
      failed++; $display("FAIL midreset_reach_beat7: got %0d reads, want 7", reads);
    end
    i_cache_miss = 1'b0; i_mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (o_memory_response !== 1'b0 || o_mem_req !== 1'b0) begin
      failed++; $display("FAIL midreset_no_rsp: got rsp=%b req=%b, want 0 0", o_memory_response, o_mem_req);
    end
    rst = 1'b1;
    run_miss(32'h0000_4000, 1'b0, 32'h0, '0, 0);
    expect_reads(32'h0000_4000, 1, 1);
    check_seq("after_reset", N + 1, N + 2, 32'h0000_4000);
  endtask

  task automatic test_back_to_back();
    salt = $urandom;
    run_miss(32'h0000_0100, 1'b0, 32'h0, '0, 0);
    expect_reads(32'h0000_0100, 1, 1);
    check_seq("b2b_first", N + 1, N + 2, 32'h0000_0100);
    run_miss(32'h0000_0F3C, 1'b0, 32'h0, '0, 0);
    expect_reads(32'h0000_0F00, 1, 1);
    check_seq("b2b_second", N + 1, N + 2, 32'h0000_0F00);
  endtask

`ifdef CACHE_REFILL_CTL_PERF_EN
  task automatic test_perf();
    apply_reset();
    tests++;
    if (o_miss_count !== 0 || o_evict_count !== 0 || o_stall_cycles !== 0) begin
      failed++; $display("FAIL perf_reset: got %0d %0d %0d, want 0 0 0", o_miss_count, o_evict_count, o_stall_cycles);
    end
    run_miss(32'h0000_1000, 1'b0, 32'h0, '0, 0);
    run_miss(32'h0000_2000, 1'b1, 32'h0000_9000, rand_line(), 0);
    run_miss(32'h0000_3000, 1'b0, 32'h0, '0, 0);
    tests++;
    if (o_miss_count !== 32'd3 || o_evict_count !== 32'd1 || o_stall_cycles !== 32'd70) begin
      failed++; $display("FAIL perf_counts: got miss=%0d evict=%0d stall=%0d, want 3 1 70", o_miss_count, o_evict_count, o_stall_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
`ifdef CACHE_REFILL_CTL_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
